// File: rtl/bar_chk_pkg.sv
// bar_chk_pkg: shared types and constants for the LED bar pattern checker.
// Holds the tracker state enum, the level-width helper and the DIR encodings.
package bar_chk_pkg;

  // Tracker state: no reference level, one reference level, or phase-locked.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  // DIR encodings: fill walks the level up, drain walks it down.
  localparam logic DIR_FILL  = 1'b1;
  localparam logic DIR_DRAIN = 1'b0;

  // Bits needed to hold a level in 0..width inclusive.
  function automatic int calc_lw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bar_pattern_checker_thermo_decode.sv
// thermo_decode: combinational LSB-anchored thermometer decoder.
// A code is legal when it has the form 2^n - 1 (a run of ones from bit 0);
// the decoded level is then n. Reusable for any thermometer-coded display.
module thermo_decode import bar_chk_pkg::*; #(
  parameter  int WIDTH = 8,
  localparam int LW    = calc_lw(WIDTH)
) (
  input  logic [WIDTH-1:0] bar_i,
  output logic             legal_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] bar_plus_one;

  // A run of ones from the LSB plus one has no bit in common with itself
  // (all-ones wraps to zero), so that test alone classifies the code.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    bar_plus_one = bar_i + 1'b1;
    legal_o      = ((bar_i & bar_plus_one) == '0);
    level_o      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      level_o = level_o + LW'(bar_i[i]);
    end
  end

endmodule

// File: rtl/bar_pattern_checker.sv
// bar_pattern_checker: receive-side monitor for the LED bar fill/drain
// generator. Decodes each qualified BAR sample, tracks the fill/drain phase,
// flags illegal codes and illegal steps, and counts completed periods.
// Optional build macro BAR_HOLD_TOLERATE_EN: a legal sample equal to the
// current level in SYNC or LOCKED is treated as a stall rather than a step.
module bar_pattern_checker import bar_chk_pkg::*; #(
  parameter  int WIDTH = 8,
  parameter  int CYC_W = 16,
  localparam int LW    = calc_lw(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] BAR,
  output logic [LW-1:0]    LEVEL,
  output logic             DIR,
  output logic             LOCKED,
  output logic             ERR_CODE,
  output logic             ERR_STEP,
  output logic [7:0]       ERR_CNT,
  output logic [CYC_W-1:0] CYC_CNT
);

`ifdef BAR_HOLD_TOLERATE_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  localparam logic [LW-1:0] LVL_MAX = LW'(WIDTH);

  state_e           state_q;
  logic [LW-1:0]    level_q;
  logic             dir_q;
  logic             locked_q;
  logic             err_code_q;
  logic             err_step_q;
  logic [7:0]       err_cnt_q;
  logic [CYC_W-1:0] cyc_cnt_q;

  logic             dec_legal;
  logic [LW-1:0]    dec_level;

  logic [LW-1:0]    exp_level;
  logic             exp_dir;
  logic             is_up;
  logic             is_dn;
  logic             is_hold;
  logic [7:0]       err_cnt_d;
  logic [CYC_W-1:0] cyc_cnt_d;

  thermo_decode #(.WIDTH(WIDTH)) u_decode (
    .bar_i   (BAR),
    .legal_o (dec_legal),
    .level_o (dec_level)
  );

  // Expected next step of the legal sequence and the sample's relation to LEVEL.
  always_comb begin
    exp_level = level_q;
    exp_dir   = dir_q;
    if (dir_q == DIR_FILL) begin
      if (level_q == LVL_MAX) begin
        exp_level = LVL_MAX - 1'b1;
        exp_dir   = DIR_DRAIN;
      end else begin
        exp_level = level_q + 1'b1;
        exp_dir   = DIR_FILL;
      end
    end else begin
      if (level_q == '0) begin
        exp_level = LW'(1);
        exp_dir   = DIR_FILL;
      end else begin
        exp_level = level_q - 1'b1;
        exp_dir   = DIR_DRAIN;
      end
    end

    // Compare one bit wider so +1 at the top level cannot wrap.
    is_up   = ({1'b0, dec_level} == ({1'b0, level_q} + 1'b1));
    is_dn   = (({1'b0, dec_level} + 1'b1) == {1'b0, level_q});
    is_hold = HOLD_EN && (dec_level == level_q);

    // Saturating increments for both counters.
    err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 1'b1;
    cyc_cnt_d = (cyc_cnt_q == '1)    ? cyc_cnt_q : cyc_cnt_q + 1'b1;
  end

  // Tracker FSM with registered outputs; responds one cycle after a sample.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before this edge, independent of order.
    if (RST) begin
      state_q    <= ST_UNLOCKED;
      level_q    <= '0;
      dir_q      <= DIR_FILL;
      locked_q   <= 1'b0;
      err_code_q <= 1'b0;
      err_step_q <= 1'b0;
      err_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
    end else begin
      // Error flags are single-cycle pulses.
      err_code_q <= 1'b0;
      err_step_q <= 1'b0;
      if (IN_VALID) begin
        if (!dec_legal) begin
          // Illegal code from any state drops tracking; LEVEL holds.
          err_code_q <= 1'b1;
          err_cnt_q  <= err_cnt_d;
          locked_q   <= 1'b0;
          state_q    <= ST_UNLOCKED;
        end else begin
          unique case (state_q)
            ST_UNLOCKED: begin
              level_q <= dec_level;
              state_q <= ST_SYNC;
            end
            ST_SYNC: begin
              if (is_hold) begin
                // Stall: generator has not advanced yet.
              end else if (is_up) begin
                level_q  <= dec_level;
                dir_q    <= DIR_FILL;
                locked_q <= 1'b1;
                state_q  <= ST_LOCKED;
              end else if (is_dn) begin
                level_q  <= dec_level;
                dir_q    <= DIR_DRAIN;
                locked_q <= 1'b1;
                state_q  <= ST_LOCKED;
              end else begin
                level_q <= dec_level;
              end
            end
            ST_LOCKED: begin
              if (dec_level == exp_level) begin
                level_q <= dec_level;
                dir_q   <= exp_dir;
                // Turning from 0 back to 1 starts a new fill: one period done.
                if (level_q == '0) begin
                  cyc_cnt_q <= cyc_cnt_d;
                end
              end else if (is_hold) begin
                // Stall: generator has not advanced yet.
              end else begin
                err_step_q <= 1'b1;
                err_cnt_q  <= err_cnt_d;
                locked_q   <= 1'b0;
                level_q    <= dec_level;
                state_q    <= ST_SYNC;
              end
            end
            default: begin
              state_q  <= ST_UNLOCKED;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign LEVEL    = level_q;
  assign DIR      = dir_q;
  assign LOCKED   = locked_q;
  assign ERR_CODE = err_code_q;
  assign ERR_STEP = err_step_q;
  assign ERR_CNT  = err_cnt_q;
  assign CYC_CNT  = cyc_cnt_q;

endmodule

// File: tb/tb_bar_pattern_checker.sv
// tb_bar_pattern_checker: directed and randomized bench for bar_pattern_checker.
// The reference model tracks the position within the 2*WIDTH-sample period
// instead of a level/direction pair. Honours BAR_HOLD_TOLERATE_EN if defined.
module tb_bar_pattern_checker;

  localparam int W     = 8;
  localparam int LW    = 4;
  localparam int CYC_W = 16;
  localparam int PER   = 2 * W;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             IN_VALID = 1'b0;
  logic [W-1:0]     BAR = '0;
  logic [LW-1:0]    LEVEL;
  logic             DIR;
  logic             LOCKED;
  logic             ERR_CODE;
  logic             ERR_STEP;
  logic [7:0]       ERR_CNT;
  logic [CYC_W-1:0] CYC_CNT;

  int tests = 0;
  int fails = 0;

  bar_pattern_checker #(.WIDTH(W), .CYC_W(CYC_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .BAR      (BAR),
    .LEVEL    (LEVEL),
    .DIR      (DIR),
    .LOCKED   (LOCKED),
    .ERR_CODE (ERR_CODE),
    .ERR_STEP (ERR_STEP),
    .ERR_CNT  (ERR_CNT),
    .CYC_CNT  (CYC_CNT)
  );

  always #5 CLK = ~CLK;

`ifdef BAR_HOLD_TOLERATE_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // Reference model: mode 0 = no reference, 1 = one reference level, 2 = locked.
  int m_mode, m_pos, m_lvl, m_dir, m_locked, m_ecode, m_estep, m_ecnt, m_ccnt;

  function automatic int level_at(input int pos);
    return (pos <= W) ? pos : PER - pos;
  endfunction

  function automatic logic [W-1:0] bar_of(input int n);
    return W'((1 << n) - 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_lvl = 0; m_dir = 1; m_locked = 0;
    m_ecode = 0; m_estep = 0; m_ecnt = 0; m_ccnt = 0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] b);
    int  n;
    bit  legal;
    int  np;
    legal = 0; n = 0;
    for (int k = 0; k <= W; k++) if (b == bar_of(k)) begin legal = 1; n = k; end
    m_ecode = 0; m_estep = 0;
    if (!v) return;
    if (!legal) begin
      m_ecode = 1; m_locked = 0; m_mode = 0;
      if (m_ecnt < 255) m_ecnt++;
    end else if (m_mode == 0) begin
      m_lvl = n; m_mode = 1;
    end else if (m_mode == 1) begin
      if (n == m_lvl + 1) begin
        m_pos = n; m_lvl = n; m_dir = 1; m_locked = 1; m_mode = 2;
      end else if (n + 1 == m_lvl) begin
        m_pos = (PER - n) % PER; m_lvl = n; m_dir = 0; m_locked = 1; m_mode = 2;
      end else if (!(HOLD && n == m_lvl)) begin
        m_lvl = n;
      end
    end else begin
      np = (m_pos + 1) % PER;
      if (n == level_at(np)) begin
        if (m_pos == 0 && m_ccnt < 65535) m_ccnt++;
        m_pos = np; m_lvl = n; m_dir = (np >= 1 && np <= W) ? 1 : 0;
      end else if (!(HOLD && n == m_lvl)) begin
        m_estep = 1; m_locked = 0; m_mode = 1; m_lvl = n;
        if (m_ecnt < 255) m_ecnt++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("level",    32'(LEVEL),    32'(m_lvl));
    check("dir",      32'(DIR),      32'(m_dir));
    check("locked",   32'(LOCKED),   32'(m_locked));
    check("err_code", 32'(ERR_CODE), 32'(m_ecode));
    check("err_step", 32'(ERR_STEP), 32'(m_estep));
    check("err_cnt",  32'(ERR_CNT),  32'(m_ecnt));
    check("cyc_cnt",  32'(CYC_CNT),  32'(m_ccnt));
  endtask

  // One clock: drive, let the edge happen, update the model, compare #1 later.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] b);
    RST = rst; IN_VALID = v; BAR = b;
    @(posedge CLK);
    #1;
    if (rst) model_reset(); else model_step(v, b);
    check_model();
  endtask

  task automatic feed(input int n);
    step(1'b0, 1'b1, bar_of(n));
  endtask

  initial begin
    int gp, r;
    logic v;
    logic [W-1:0] b;
    model_reset();

    // Reset state.
    #1;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 8'h5A);
    check("rst_level", 32'(LEVEL), 0);
    check("rst_dir", 32'(DIR), 1);
    check("rst_locked", 32'(LOCKED), 0);

    // Three clean periods.
    for (int k = 0; k < 3 * PER; k++) begin
      feed(level_at(k % PER));
      if (k >= 1) check("lock_from_2nd", 32'(LOCKED), 1);
      if (k == 9) check("dir_after_ff_7f", 32'(DIR), 0);
      if (k == 17) check("dir_after_00_01", 32'(DIR), 1);
    end
    check("cyc_after_3rd", 32'(CYC_CNT), 2);
    check("no_err_periods", 32'(ERR_CNT), 0);

    // Illegal code while locked at level 3, then relock.
    feed(0); feed(1); feed(2); feed(3);
    step(1'b0, 1'b1, 8'h05);
    check("inj_code", 32'(ERR_CODE), 1);
    check("inj_code_nostep", 32'(ERR_STEP), 0);
    check("inj_code_unlock", 32'(LOCKED), 0);
    check("inj_code_cnt", 32'(ERR_CNT), 1);
    feed(4); feed(5);
    check("relock", 32'(LOCKED), 1);
    check("relock_level", 32'(LEVEL), 5);

    // Step error: at level 4 filling, jump back to level 2.
    feed(6); feed(7); feed(8); feed(7); feed(6); feed(5); feed(4);
    feed(3); feed(2); feed(1); feed(0); feed(1); feed(2); feed(3); feed(4);
    step(1'b0, 1'b1, 8'h03);
    check("step_err", 32'(ERR_STEP), 1);
    check("step_err_nocode", 32'(ERR_CODE), 0);
    check("step_err_level", 32'(LEVEL), 2);
    check("step_err_cnt", 32'(ERR_CNT), 2);

    // Invalid cycles carrying garbage are ignored.
    step(1'b0, 1'b0, 8'hA5); step(1'b0, 1'b0, 8'hA5); step(1'b0, 1'b0, 8'hA5);
    feed(3);
    step(1'b0, 1'b0, 8'hA5);
    feed(4);
    step(1'b0, 1'b0, 8'hA5);
    feed(5);
    check("gap_locked", 32'(LOCKED), 1);
    check("gap_errcnt", 32'(ERR_CNT), 2);

    // Repeated sample while locked at level 3 (draining).
    feed(6); feed(7); feed(8); feed(7); feed(6); feed(5); feed(4); feed(3);
    feed(3);
`ifdef BAR_HOLD_TOLERATE_EN
    check("hold_nostep", 32'(ERR_STEP), 0);
    check("hold_locked", 32'(LOCKED), 1);
`else
    check("repeat_step", 32'(ERR_STEP), 1);
    check("repeat_unlock", 32'(LOCKED), 0);
`endif

    // Randomized generator with stalls, gaps, corruptions and skips.
    gp = 0;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 19);
      b = bar_of(level_at(gp));
      if (r == 0) b = W'($urandom);
      step(1'b0, v, b);
      if (v && r != 1) gp = (gp + ((r == 2) ? 2 : 1)) % PER;
    end

    // Error counter saturation.
    for (int k = 0; k < 300; k++) step(1'b0, 1'b1, 8'hA5);
    check("err_sat", 32'(ERR_CNT), 255);

    // Reset mid-sequence overrides IN_VALID.
    feed(3); feed(2);
    step(1'b1, 1'b1, 8'h0F);
    check("mid_rst_level", 32'(LEVEL), 0);
    check("mid_rst_dir", 32'(DIR), 1);
    check("mid_rst_locked", 32'(LOCKED), 0);
    check("mid_rst_code", 32'(ERR_CODE), 0);
    check("mid_rst_step", 32'(ERR_STEP), 0);
    check("mid_rst_errcnt", 32'(ERR_CNT), 0);
    check("mid_rst_cyccnt", 32'(CYC_CNT), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
